ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
Parametrised, clocked EX/MEM pipeline register for the pipelined MIPS datapath. It replaces the combinational delay-latch style with a true edge-triggered stage. The stage adds a valid/ready handshake, an optional skid buffer, a flush (bubble insertion) input and a saturating stall counter. It sits between the EX stage (ALU, branch adder, dest-reg mux) and the MEM stage (data memory, branch resolution).

Parameters:
DATA_W, 32, width of add_result, alu_result and rdata2 paths
REG_W, 5, width of the destination register index
WB_W, 2, width of the write-back control bundle
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all held entries and any same-cycle input
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept this cycle
ctlwb_in  in  WB_W  write-back controls
ctlm_in  in  3  [2]=branch, [1]=memread, [0]=memwrite
add_result_in  in  DATA_W  branch target
zero_in  in  1  ALU zero flag
alu_result_in  in  DATA_W  ALU result
rdata2_in  in  DATA_W  store data
dest_in  in  REG_W  destination register index
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM stage accepts this cycle
wb_ctlout  out  WB_W  write-back controls
branch, memread, memwrite  out  1 each  MEM controls
add_result, alu_result, rdata2out  out  DATA_W  datapath values
zero  out  1  zero flag
dest_out  out  REG_W  destination register index
stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous): both entries invalid, all outputs 0, stall_count 0. in_ready reads 1 from the first edge after release.
- Transfer in = in_valid & in_ready & ~flush. Transfer out = out_valid & out_ready.
- Latency: 1 cycle. Data accepted at edge N is visible on the outputs after edge N.
- SKID=1 state machine:
  - States: EMPTY (no entries), FULL (main entry), SKID (main + skid). in_ready = (state != SKID), registered.
  - EMPTY -> FULL on transfer in.
  - FULL -> EMPTY on transfer out with no transfer in.
  - FULL -> FULL on in+out together: main is replaced by the new input.
  - FULL -> SKID on transfer in with no transfer out: the input goes to the skid register.
  - SKID -> FULL on transfer out: skid moves to main. No input is accepted this cycle.
- SKID=0: one register only. in_ready = ~out_valid | out_ready, combinational. Back-to-back throughput is 1 per cycle.
- Ordering: strict FIFO order is required; no entry may be lost or duplicated.
- flush: at the next edge all entries are invalidated (state EMPTY) and any same-cycle input is discarded. Flush has priority over in and out. A same-cycle transfer out still completes on the MEM side.
- Bubble safety: whenever out_valid=0, wb_ctlout, branch, memread and memwrite must read 0. Datapath outputs hold their last values.
- Stalls: while out_valid=1 and out_ready=0, all outputs must be held stable.
- stall_count increments each cycle with out_valid=1 and out_ready=0. It saturates at all-ones and is cleared only by reset.
- Widths: no arithmetic on the payload. zero, dest and control fields pass through unmodified.

Decomposition:
- Package ex_mem_pkg holds:
  - MEM control bit indices (BR_BIT=2, MR_BIT=1, MW_BIT=0)
  - a packed payload struct parametrised by widths (or a localparam PAYLOAD_W)
  - the state encoding (EMPTY, FULL, SKID)
- Sub-module pipe_skid_reg: a generic payload-width valid/ready register with the SKID mode and flush. ex_mem_pipe packs and unpacks the fields around it, gates the controls and owns stall_count.

Test Plan:
- Reset mid-stream: assert rst_n=0 with state SKID -> outputs 0 immediately, without waiting for an edge; stall_count=0; in_ready=1 after release.
- Streaming, out_ready=1: alu_result_in = 0x10, 0x11, 0x12 on consecutive cycles -> same sequence on alu_result 1 cycle later; out_valid continuous.
- Backpressure, SKID=1: out_ready=0 for 3 cycles while feeding 0xA0, 0xA1 -> in_ready falls after the second accept; outputs stay 0xA0; stall_count=3; releasing out_ready yields 0xA0 then 0xA1 with no loss.
- Flush with simultaneous input: state FULL, in_valid=1 (memwrite=1) and flush=1 -> next cycle out_valid=0 and memwrite=0; the input never appears.
- SKID=0 mode: out_ready toggles 1,0,1 with continuous input -> in_ready mirrors ~out_valid|out_ready combinationally; order preserved.
- Counter saturation with CNT_W=4: hold out_ready=0 for 20 cycles with out_valid=1 -> stall_count stops at 15.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: MEM control bit positions,
// payload sizing and the skid-buffer state encoding.
package ex_mem_pkg;

  localparam int CTLM_W = 3;
  localparam int BR_BIT = 2;
  localparam int MR_BIT = 1;
  localparam int MW_BIT = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // Packed order: {ctlwb, ctlm, add_result, zero, alu_result, rdata2, dest}
  function automatic int payload_w(input int data_w, input int reg_w, input int wb_w);
    return wb_w + CTLM_W + 3 * data_w + 1 + reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with flush; SKID selects a two-entry
// skid buffer (registered in_ready) or a single register (combinational in_ready).
module pipe_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (SKID) begin : g_skid
    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_rdy;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_ld_main_in;
    logic         w_ld_main_skid;
    logic         w_ld_skid;

    assign w_in_xfer  = in_valid & r_rdy & ~flush;
    assign w_out_xfer = (r_state != ST_EMPTY) & out_ready;

    always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              w_state_nxt  = ST_FULL;
              w_ld_main_in = 1'b1;
            end
          end
          ST_FULL: begin
            if (w_in_xfer && w_out_xfer) begin
              w_ld_main_in = 1'b1;
            end else if (w_in_xfer) begin
              w_state_nxt = ST_SKID;
              w_ld_skid   = 1'b1;
            end else if (w_out_xfer) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_SKID: begin
            // in_ready is low here, so the skid entry just drains into main
            if (w_out_xfer) begin
              w_state_nxt    = ST_FULL;
              w_ld_main_skid = 1'b1;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_EMPTY;
        r_rdy   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rdy   <= (w_state_nxt != ST_SKID);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_ld_main_in) begin
          r_main <= in_data;
        end else if (w_ld_main_skid) begin
          r_main <= r_skid;
        end
        if (w_ld_skid) begin
          r_skid <= in_data;
        end
      end
    end

    assign in_ready  = r_rdy;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
  end else begin : g_single
    logic         r_valid;
    logic [W-1:0] r_main;
    logic         w_rdy;
    logic         w_in_xfer;

    assign w_rdy     = ~r_valid | out_ready;
    assign w_in_xfer = in_valid & w_rdy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main <= '0;
      end else if (w_in_xfer) begin
        r_main <= in_data;
      end
    end

    assign in_ready  = w_rdy;
    assign out_valid = r_valid;
    assign out_data  = r_main;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Edge-triggered EX/MEM pipeline stage: packs the EX outputs into one payload,
// gates MEM/WB controls on bubbles and counts stalled cycles.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [DATA_W-1:0] add_result_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic              zero,
  output logic [REG_W-1:0]  dest_out,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int PW = payload_w(DATA_W, REG_W, WB_W);

  logic [PW-1:0]     w_in_payload;
  logic [PW-1:0]     w_out_payload;
  logic [WB_W-1:0]   w_wb;
  logic [CTLM_W-1:0] w_ctlm;
  logic [CNT_W-1:0]  r_stall_count;

  assign w_in_payload = {ctlwb_in, ctlm_in, add_result_in, zero_in,
                         alu_result_in, rdata2_in, dest_in};

  pipe_skid_reg #(
    .W    (PW),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign {w_wb, w_ctlm, add_result, zero, alu_result, rdata2out, dest_out} = w_out_payload;

  // Controls are forced low on bubbles so MEM/WB never act on a stale entry
  assign wb_ctlout = out_valid ? w_wb : '0;
  assign branch    = out_valid & w_ctlm[BR_BIT];
  assign memread   = out_valid & w_ctlm[MR_BIT];
  assign memwrite  = out_valid & w_ctlm[MW_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (out_valid && !out_ready && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule
